// File: rtl/dcache_mem_ctrl_pkg.sv
// rtl/dcache_mem_ctrl_pkg.sv - shared bus, size and request types for the dcache memory controller
`ifndef LSQSZ
`define LSQSZ 8
`endif

package dcache_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    REQ_WB = 2'h0,
    REQ_ST = 2'h1,
    REQ_LD = 2'h2
  } REQ_KIND;

  typedef struct packed {
    REQ_KIND             kind;
    logic [15:0]         addr;
    logic [63:0]         data;
    MEM_SIZE             size;
    logic [2:0]          offset;
    logic [`LSQSZ-1:0]   gnt;
  } mem_req_t;

  typedef struct packed {
    logic                valid;
    logic [15:0]         addr;
    MEM_SIZE             size;
    logic [`LSQSZ-1:0]   gnt;
  } ld_entry_t;

  // Shift the addressed bytes down to bit 0, then zero everything above the access size.
  function automatic logic [63:0] extract_load(input logic [63:0] blk, input logic [2:0] off,
                                               input MEM_SIZE size);
    logic [63:0] sh;
    sh = blk >> {off, 3'b000};
    case (size)
      BYTE:    extract_load = {56'b0, sh[7:0]};
      HALF:    extract_load = {48'b0, sh[15:0]};
      WORD:    extract_load = {32'b0, sh[31:0]};
      default: extract_load = sh;
    endcase
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl_multi_enq_fifo.sv
// rtl/dcache_mem_ctrl_multi_enq_fifo.sv - request FIFO with three ordered enqueue ports and one dequeue port
module multi_enq_fifo
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [2:0]     enq_en_i,
  input  mem_req_t [2:0] enq_req_i,
  input  logic           deq_i,
  output mem_req_t       head_o,
  output logic           empty_o,
  output logic           full_o
);

  localparam int PW = $clog2(DEPTH);

  mem_req_t        mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [PW:0]     free_slots, nacc;
  logic [2:0]      acc;
  logic [PW-1:0]   slot [3];
  logic            do_deq;
  logic            full_q;

  // Enabled ports pack into consecutive tail slots; a port that finds no room is refused.
  always_comb begin
    do_deq     = deq_i && (count_q != '0);
    free_slots = (PW+1)'(DEPTH) - count_q;
    nacc       = '0;
    acc        = '0;
    for (int k = 0; k < 3; k++) begin
      slot[k] = tail_q + nacc[PW-1:0];
      acc[k]  = enq_en_i[k] && (nacc < free_slots);
      nacc    = nacc + {{PW{1'b0}}, acc[k]};
    end
    head_d  = head_q + PW'(do_deq);
    tail_d  = tail_q + nacc[PW-1:0];
    count_d = count_q + nacc - (PW+1)'(do_deq);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= ((PW+1)'(DEPTH) - count_d) < (PW+1)'(3);
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) mem_q[slot[k]] <= enq_req_i[k];
      end
    end
  end

  assign head_o  = mem_q[head_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// rtl/dcache_mem_ctrl.sv - dcache memory-side responder: ordered bus issue, load tag tracking, fill and LSQ completion
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int QDEPTH       = 8,
  parameter int NUM_MEM_TAGS = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wb_en,
  input  logic [15:0]        wb_addr,
  input  logic [63:0]        wb_data,
  input  logic [1:0]         wb_size,
  input  logic               wr_en,
  input  logic [15:0]        wr_addr,
  input  logic [63:0]        wr_data,
  input  logic [1:0]         wr_size,
  input  logic               rd_en,
  input  logic [15:0]        rd_addr,
  input  logic [1:0]         rd_size,
  input  logic [`LSQSZ-1:0]  rd_gnt,
  output logic               req_full,
  input  logic               mem_grant,
  output logic [1:0]         proc2mem_command,
  output logic [15:0]        proc2mem_addr,
  output logic [63:0]        proc2mem_data,
  output logic [1:0]         proc2mem_size,
  input  logic [3:0]         mem2proc_response,
  input  logic [63:0]        mem2proc_data,
  input  logic [3:0]         mem2proc_tag,
  output logic               mem_wr_en,
  output logic [4:0]         mem_wr_idx,
  output logic [7:0]         mem_wr_tag,
  output logic [63:0]        mem_wr_data,
  output logic               ld_done,
  output logic [`LSQSZ-1:0]  ld_gnt,
  output logic [63:0]        ld_data
);

  mem_req_t [2:0] enq_req;
  mem_req_t       head;
  logic           q_empty, issue, accept, resp_ok, tag_ok, cpl_hit;
  ld_entry_t      tbl_q [NUM_MEM_TAGS+1];
  ld_entry_t      cpl;

  always_comb begin
    enq_req[0] = '{kind: REQ_WB, addr: wb_addr, data: wb_data, size: MEM_SIZE'(wb_size),
                   offset: wb_addr[2:0], gnt: '0};
    enq_req[1] = '{kind: REQ_ST, addr: wr_addr, data: wr_data, size: MEM_SIZE'(wr_size),
                   offset: wr_addr[2:0], gnt: '0};
    enq_req[2] = '{kind: REQ_LD, addr: rd_addr, data: '0, size: MEM_SIZE'(rd_size),
                   offset: rd_addr[2:0], gnt: rd_gnt};
  end

  multi_enq_fifo #(.DEPTH(QDEPTH)) u_req_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .enq_en_i  ({rd_en, wr_en, wb_en}),
    .enq_req_i (enq_req),
    .deq_i     (accept),
    .head_o    (head),
    .empty_o   (q_empty),
    .full_o    (req_full)
  );

  assign issue   = !reset && !q_empty && mem_grant;
  assign accept  = issue && (mem2proc_response != 4'd0);
  assign resp_ok = int'(mem2proc_response) <= NUM_MEM_TAGS;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (issue) begin
      if (head.kind == REQ_LD) begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = {head.addr[15:3], 3'b000};
        proc2mem_size    = DOUBLE;
      end else begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = head.addr;
        proc2mem_data    = head.data;
        proc2mem_size    = head.size;
      end
    end
  end

  // A returning tag with no live entry (stray or cleared by reset) produces nothing.
  assign tag_ok  = (mem2proc_tag != 4'd0) && (int'(mem2proc_tag) <= NUM_MEM_TAGS);
  assign cpl     = tbl_q[mem2proc_tag];
  assign cpl_hit = !reset && tag_ok && cpl.valid;

  always_comb begin
    mem_wr_en   = cpl_hit;
    ld_done     = cpl_hit;
    mem_wr_idx  = '0;
    mem_wr_tag  = '0;
    mem_wr_data = '0;
    ld_gnt      = '0;
    ld_data     = '0;
    if (cpl_hit) begin
      mem_wr_idx  = cpl.addr[7:3];
      mem_wr_tag  = cpl.addr[15:8];
      mem_wr_data = mem2proc_data;
      ld_gnt      = cpl.gnt;
      ld_data     = extract_load(mem2proc_data, cpl.addr[2:0], cpl.size);
    end
  end

  // Allocation is written after invalidation so a same-tag reuse keeps the new entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NUM_MEM_TAGS; i++) tbl_q[i] <= '0;
    end else begin
      if (cpl_hit) tbl_q[mem2proc_tag].valid <= 1'b0;
      if (accept && head.kind == REQ_LD && resp_ok)
        tbl_q[mem2proc_response] <= '{valid: 1'b1, addr: head.addr, size: head.size, gnt: head.gnt};
    end
  end

endmodule
